alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request-queue depth (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  request queue can accept.
REQ-006 SHALL have ports req_a, req_b  input  4  operands.
REQ-007 SHALL have port req_sel  input  3  opcode.
REQ-008 SHALL have ports A, B  output  4  registered operands driven to the downstream combinational ALU.
REQ-009 SHALL have port ALU_Sel  output  3  registered opcode to the ALU.
REQ-010 SHALL have port ALU_Out  input  4  ALU combinational result.
REQ-011 SHALL have port resp_valid  output  1  result available.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-013 SHALL have port resp_data  output  4  captured result.

Function
REQ-014 SHALL push {req_a, req_b, req_sel} into a FIFO on any edge where req_valid && req_ready.
REQ-015 SHALL drive req_ready = !full; a pop in the same cycle SHALL NOT raise req_ready when full.
REQ-016 SHALL support simultaneous push and pop; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL implement FSM IDLE -> DRIVE -> HOLD -> IDLE.
REQ-018 IDLE: if FIFO non-empty, pop head, register into A/B/ALU_Sel, go DRIVE; else stay.
REQ-019 DRIVE: hold A/B/ALU_Sel one cycle; on next edge capture ALU_Out into resp_data, set resp_valid, go HOLD.
REQ-020 HOLD: keep resp_valid, resp_data, A, B, ALU_Sel stable until resp_valid && resp_ready; then clear resp_valid, go IDLE.
REQ-021 Latency: request accepted at edge N into empty FIFO, consumer ready -> A/B/ALU_Sel valid after N+1, resp_valid high after N+2; throughput one result per 3 cycles.
REQ-022 SHALL pass opcodes 101/110/111 unmodified; the ALU yields 0000 for them.
REQ-023 SHALL preserve request order; no request dropped or duplicated.

Reset
REQ-024 On rst asserted, immediately: FSM IDLE, FIFO empty, A=B=0, ALU_Sel=000, resp_data=0, resp_valid=0, req_ready=0 while rst high, 1 in first cycle after release.
REQ-025 Reset mid-operation SHALL discard queued and in-flight requests without emitting a response.

Configuration
REQ-026 Macro ALU_ISSUE_FLAGS_EN SHALL, when defined, add outputs resp_zero (1, resp_data==0) and resp_illegal (1, captured opcode >=101), registered with resp_data, reset 0.
REQ-027 Without ALU_ISSUE_FLAGS_EN those ports and their logic SHALL NOT exist; all other behaviour identical.

Structure
REQ-028 Package alu_pkg SHALL hold DATA_W=4, SEL_W=3, opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_NOT=100, and the FSM state type.
REQ-029 FIFO SHALL be sub-module alu_req_fifo (parameter DEPTH; push/pop/full/empty); FSM and output registers in alu_issue_ctrl.

Verification
REQ-030 Single ADD: A=3,B=1,sel=000 accepted at edge N -> resp_valid after N+2, resp_data=4.
REQ-031 Back-to-back SUB 4-1, AND 1100&1010, OR 1100|1010, NOT 1010 with resp_ready=1 -> responses 3, 1000, 1110, 0101 in order, 3 cycles apart.
REQ-032 resp_ready=0, push 5 requests (DEPTH=4) -> req_ready low once 4 queued (1 in flight + 4 queued allowed); release resp_ready -> all 5 results correct, in order.
REQ-033 Opcode 111 with A=5,B=2 -> resp_data=0000; with ALU_ISSUE_FLAGS_EN resp_illegal=1, resp_zero=1.
REQ-034 rst pulsed during HOLD with 2 queued -> resp_valid=0 immediately, no further responses, all outputs 0.
REQ-035 Push and pop in same cycle at occupancy 2 -> occupancy stays 2, pointer wrap verified across 10 requests.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, opcodes, request payload and FSM state type for the ALU issue controller.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
  localparam logic [SEL_W-1:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request queue for the ALU issue controller: DEPTH entries (power of 2), pointers wrap naturally.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_req_t push_data,
  input  logic     pop,
  output alu_req_t head_c,
  output logic     full,
  output logic     empty,
  output logic     full_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  alu_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  assign full_nxt_c = (count_nxt == CW'(DEPTH));
  assign head_c     = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= full_nxt_c;
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues ALU requests, drives one at a time to an external combinational ALU and holds each result.
// Optional macro ALU_ISSUE_FLAGS_EN adds resp_zero / resp_illegal result flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [SEL_W-1:0]  req_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] ALU_Out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              resp_zero,
  output logic              resp_illegal
`endif
);

  state_t   state;
  state_t   state_nxt;
  alu_req_t req_c;
  alu_req_t head_c;
  logic     push_c;
  logic     pop_c;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_full_nxt_c;

  assign req_c  = '{a: req_a, b: req_b, sel: req_sel};
  assign push_c = req_valid && req_ready && !fifo_full;

  alu_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .push_data  (req_c),
    .pop        (pop_c),
    .head_c     (head_c),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .full_nxt_c (fifo_full_nxt_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the pop strobe that loads the ALU operand registers.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (resp_valid && resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ready is registered from next occupancy, so a pop while full cannot raise it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b0;
      A          <= '0;
      B          <= '0;
      ALU_Sel    <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
    end else begin
      req_ready <= !fifo_full_nxt_c;
      if (pop_c) begin
        A       <= head_c.a;
        B       <= head_c.b;
        ALU_Sel <= head_c.sel;
      end
      if (state == ST_DRIVE) begin
        resp_data  <= ALU_Out;
        resp_valid <= 1'b1;
      end else if (state == ST_HOLD && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  // Flags are captured on the same edge as resp_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_zero    <= 1'b0;
      resp_illegal <= 1'b0;
    end else if (state == ST_DRIVE) begin
      resp_zero    <= (ALU_Out == '0);
      resp_illegal <= (ALU_Sel > OP_NOT);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural combinational ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_a = '0;
  logic [DATA_W-1:0] req_b = '0;
  logic [SEL_W-1:0]  req_sel = '0;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [SEL_W-1:0]  ALU_Sel;
  logic [DATA_W-1:0] ALU_Out;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DATA_W-1:0] resp_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic              resp_zero;
  logic              resp_illegal;
  logic              zero_q[$];
  logic              ill_q[$];
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [DATA_W-1:0] got_q[$];
  int                cyc_q[$];

  alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .A          (A),
    .B          (B),
    .ALU_Sel    (ALU_Sel),
    .ALU_Out    (ALU_Out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .resp_zero    (resp_zero),
    .resp_illegal (resp_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Downstream ALU: reserved opcodes yield zero.
  always_comb begin
    case (ALU_Sel)
      OP_ADD:  ALU_Out = A + B;
      OP_SUB:  ALU_Out = A - B;
      OP_AND:  ALU_Out = A & B;
      OP_OR:   ALU_Out = A | B;
      OP_NOT:  ALU_Out = ~A;
      default: ALU_Out = '0;
    endcase
  end

  // Response log: one entry per accepted result, stamped with the cycle of the handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && resp_valid && resp_ready) begin
      got_q.push_back(resp_data);
      cyc_q.push_back(cyc);
`ifdef ALU_ISSUE_FLAGS_EN
      zero_q.push_back(resp_zero);
      ill_q.push_back(resp_illegal);
`endif
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [SEL_W-1:0] sel);
    logic acc;
    logic was_ready;
    int   n;
    acc = 1'b0;
    n   = 0;
    req_a = a;
    req_b = b;
    req_sel = sel;
    req_valid = 1'b1;
    while (!acc && n < 40) begin
      was_ready = req_ready;
      tick();
      acc = was_ready;
      n++;
    end
    req_valid = 1'b0;
    tests++;
    assert (acc) else begin
      fails++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
  endtask

  task automatic wait_resps(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk("resp_count", got_q.size(), n);
  endtask

  task automatic clear_log();
    got_q.delete();
    cyc_q.delete();
`ifdef ALU_ISSUE_FLAGS_EN
    zero_q.delete();
    ill_q.delete();
`endif
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_sel", ALU_Sel, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", req_ready, 1);

    // Single ADD latency: A/B after N+1, resp after N+2
    send(4'd3, 4'd1, OP_ADD);
    chk("add_n_valid", resp_valid, 0);
    tick();
    chk("add_A", A, 3);
    chk("add_B", B, 1);
    chk("add_sel", ALU_Sel, 0);
    chk("add_n1_valid", resp_valid, 0);
    tick();
    chk("add_n2_valid", resp_valid, 1);
    chk("add_data", resp_data, 4);
    tick();
    chk("add_n3_cleared", resp_valid, 0);
    chk("add_logged", got_q[0], 4);
    clear_log();

    // Back-to-back SUB/AND/OR/NOT
    send(4'd4, 4'd1, OP_SUB);
    send(4'b1100, 4'b1010, OP_AND);
    send(4'b1100, 4'b1010, OP_OR);
    send(4'b1010, 4'b0000, OP_NOT);
    wait_resps(4);
    chk("b2b_sub", got_q[0], 3);
    chk("b2b_and", got_q[1], 4'b1000);
    chk("b2b_or", got_q[2], 4'b1110);
    chk("b2b_not", got_q[3], 4'b0101);
    chk("b2b_gap1", cyc_q[1] - cyc_q[0], 3);
    chk("b2b_gap2", cyc_q[2] - cyc_q[1], 3);
    chk("b2b_gap3", cyc_q[3] - cyc_q[2], 3);
    clear_log();

    // Backpressure: 1 in flight + 4 queued, then drain
    resp_ready = 1'b0;
    send(4'd1, 4'd2, OP_ADD);
    send(4'd2, 4'd5, OP_SUB);
    send(4'd7, 4'd5, OP_AND);
    send(4'd8, 4'd1, OP_OR);
    send(4'd15, 4'd1, OP_ADD);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_hold_valid", resp_valid, 1);
    chk("bp_hold_data", resp_data, 3);
    resp_ready = 1'b1;
    tick();
    chk("bp_ready_still_low", req_ready, 0);
    wait_resps(5);
    chk("bp_r0", got_q[0], 3);
    chk("bp_r1", got_q[1], 13);
    chk("bp_r2", got_q[2], 5);
    chk("bp_r3", got_q[3], 9);
    chk("bp_r4", got_q[4], 0);
    chk("bp_ready_back", req_ready, 1);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("bp_zero0", zero_q[0], 0);
    chk("bp_zero4", zero_q[4], 1);
    chk("bp_ill4", ill_q[4], 0);
`endif
    clear_log();

    // Reserved opcodes pass through, ALU yields zero
    send(4'd5, 4'd2, 3'b111);
    tick();
    chk("op7_sel", ALU_Sel, 7);
    chk("op7_A", A, 5);
    chk("op7_B", B, 2);
    wait_resps(1);
    chk("op7_data", got_q[0], 0);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("op7_illegal", ill_q[0], 1);
    chk("op7_zero", zero_q[0], 1);
`endif
    send(4'd9, 4'd3, 3'b101);
    tick();
    chk("op5_sel", ALU_Sel, 5);
    send(4'd4, 4'd4, 3'b110);
    wait_resps(3);
    chk("op5_data", got_q[1], 0);
    chk("op6_data", got_q[2], 0);
    clear_log();

    // Simultaneous push/pop at occupancy 2, pointer wrap over 10 requests
    resp_ready = 1'b0;
    send(4'd0, 4'd1, OP_ADD);
    send(4'd1, 4'd1, OP_ADD);
    send(4'd2, 4'd1, OP_ADD);
    chk("occ_fill", dut.u_fifo.count, 2);
    resp_ready = 1'b1;
    tick();
    send(4'd3, 4'd1, OP_ADD);
    chk("occ_pushpop", dut.u_fifo.count, 2);
    chk("occ_ready", req_ready, 1);
    for (int i = 4; i < 10; i++) send(4'(i), 4'd1, OP_ADD);
    wait_resps(10);
    for (int i = 0; i < 10; i++) chk("wrap_order", got_q[i], i + 1);
    clear_log();

    // Reset during HOLD with two requests queued
    resp_ready = 1'b0;
    send(4'd6, 4'd3, OP_SUB);
    send(4'd1, 4'd1, OP_ADD);
    send(4'd2, 4'd2, OP_ADD);
    chk("mid_hold_valid", resp_valid, 1);
    chk("mid_hold_data", resp_data, 3);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_A", A, 0);
    chk("mid_rst_B", B, 0);
    chk("mid_rst_sel", ALU_Sel, 0);
    chk("mid_rst_data", resp_data, 0);
    chk("mid_rst_ready", req_ready, 0);
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("mid_rst_no_resp", got_q.size(), 0);
    chk("mid_rst_valid_after", resp_valid, 0);
    chk("mid_rst_A_after", A, 0);
    chk("mid_rst_data_after", resp_data, 0);
    chk("mid_rst_ready_after", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
